// File: rtl/scan_decoder.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with valid/ready handshake.
// DIRECT decodes accepted sel codes; SCAN walks every line with a programmable dwell.
module scan_decoder #(
    parameter int unsigned SEL_W      = 3,
    parameter bit          ACTIVE_LOW = 1'b0,
    parameter int unsigned DWELL      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [(1 << SEL_W)-1:0]   y,
    output logic [SEL_W-1:0]          scan_idx,
    output logic                      wrap
);

    localparam int unsigned OUT_W = 1 << SEL_W;
    localparam int unsigned CNT_W = $clog2(DWELL + 1);
    localparam logic [OUT_W-1:0] INACT    = {OUT_W{ACTIVE_LOW}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // Active word for line k; XOR with INACT applies the polarity.
    function automatic logic [OUT_W-1:0] act(input logic [SEL_W-1:0] k);
        return (OUT_W'(1) << k) ^ INACT;
    endfunction

    // Reset-safe: state is IDLE under reset, so in_ready is 0.
    assign in_ready = (state == DIRECT) && en && !mode && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            y         <= INACT;
            out_valid <= 1'b0;
            scan_idx  <= '0;
            wrap      <= 1'b0;
            cnt       <= '0;
        end else begin
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        if (mode) begin
                            state     <= SCAN;
                            out_valid <= 1'b1;
                            y         <= act(SEL_W'(0));
                            scan_idx  <= '0;
                            cnt       <= '0;
                        end else begin
                            state <= DIRECT;
                        end
                    end
                end

                DIRECT: begin
                    if (accept) begin
                        y         <= act(sel);
                        out_valid <= 1'b1;
                    end else if (!out_valid || out_ready) begin
                        // Nothing pending after this edge; leave only once the word is gone.
                        out_valid <= 1'b0;
                        y         <= INACT;
                        if (!en || mode) begin
                            state <= IDLE;
                        end
                    end
                end

                SCAN: begin
                    if (!en || !mode) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        y         <= INACT;
                        scan_idx  <= '0;
                        cnt       <= '0;
                    end else if (out_ready) begin
                        if (cnt == CNT_LAST) begin
                            cnt      <= '0;
                            scan_idx <= scan_idx + SEL_W'(1);
                            y        <= act(scan_idx + SEL_W'(1));
                            wrap     <= (scan_idx == IDX_LAST);
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    y         <= INACT;
                    scan_idx  <= '0;
                    cnt       <= '0;
                end
            endcase
        end
    end

endmodule
